dqpsk_diff_mapper: RTL and testbench
====================================

# dqpsk_diff_mapper

Differential DQPSK encoder and constellation mapper sitting directly downstream of the serial-to-parallel stage. Each incoming dibit, framed by that stage's one-cycle `valid`, becomes a phase increment. The increment is accumulated modulo 4 into a carrier-phase state, and the state is mapped to signed I/Q baseband levels for the pulse-shaping filter. An idle timeout returns the block to its reference phase, so every burst starts from a known constellation point.

## Interface
Parameters:
- `WIDTH`, 12: signed output level width in bits.
- `AMP`, 1448: constellation amplitude. Must satisfy 1 ≤ AMP ≤ 2^(WIDTH-1)-1.
- `IDLE_TIMEOUT`, 16: consecutive cycles without `valid_in` before the block returns to idle. Must be ≥ 2. Counter width is $clog2(IDLE_TIMEOUT+1).

Ports:
- `clk`, input, 1: single clock, the data-rate clock of the upstream stage. All logic is on the rising edge.
- `rstn`, input, 1: reset, asynchronous and active-low.
- `valid_in`, input, 1: one-cycle strobe marking a new dibit.
- `i_data_parallel`, input, 1: dibit MSB. Sampled only when `valid_in`=1.
- `q_data_parallel`, input, 1: dibit LSB. Sampled only when `valid_in`=1.
- `sym_valid`, output, 1: one-cycle strobe marking a new symbol on the level outputs.
- `i_level`, output, WIDTH: signed I level. Held between symbols.
- `q_level`, output, WIDTH: signed Q level. Held between symbols.
- `phase`, output, 2: current accumulated phase state, in units of 90°.
- `active`, output, 1: high while a burst is in progress.

## Operation
- Dibit to increment (Gray coded), with the dibit written as {i,q}:
  - 00 → +0
  - 01 → +1 (90°)
  - 11 → +2 (180°)
  - 10 → +3 (270°)
- On `valid_in`=1:
  - phase_next = (phase + inc) mod 4. The 2-bit add wraps naturally.
  - `phase` is registered as phase_next.
  - The mapped levels of phase_next are registered.
  - `sym_valid` is set to 1, `active` to 1, and the idle counter cleared to 0.
- Mapping (phase → I,Q):
  - 0 → (+AMP, +AMP)
  - 1 → (−AMP, +AMP)
  - 2 → (−AMP, −AMP)
  - 3 → (+AMP, −AMP)
- The level outputs are two's complement WIDTH bits. −AMP is the exact negation, with no saturation needed.
- Two-state control, IDLE and ACTIVE:
  - IDLE: `active`=0, `phase`=0, levels=0, idle counter held at 0. `valid_in` moves the block to ACTIVE. The first symbol is encoded relative to phase 0.
  - ACTIVE, no `valid_in`: the idle counter increments.
    - On the edge where the counter would reach IDLE_TIMEOUT, the block moves to IDLE: `phase`←0, `i_level`←0, `q_level`←0, `active`←0, counter←0.
    - No `sym_valid` is issued on this transition.
  - ACTIVE, `valid_in`: encode the dibit and clear the counter.
- Simultaneous events: if `valid_in` arrives on the same edge the timeout would fire, `valid_in` wins. The symbol is encoded from the current phase, not from 0, and the block stays ACTIVE.
- Back-to-back `valid_in` on consecutive cycles is legal. Each one produces one symbol.

## Timing
- Reset values, applied asynchronously while `rstn`=0: `sym_valid`=0, `i_level`=0, `q_level`=0, `phase`=0, `active`=0, state IDLE, counter 0.
- Reset is released synchronously in effect. The first edge with `rstn`=1 may sample `valid_in`.
- Latency: `valid_in` sampled at edge N gives `sym_valid`=1 and the new levels, `phase` and `active` after edge N. This is a 1-cycle registered latency.
- `sym_valid` is high for exactly one cycle per accepted dibit.
- Timeout: with the last `valid_in` at edge N, outputs go idle after edge N+IDLE_TIMEOUT, provided no `valid_in` arrives in edges N+1..N+IDLE_TIMEOUT.
- Reset asserted mid-burst: all outputs drop to their reset values immediately. The next burst starts from phase 0.

## Test plan
- Reset, then dibits 11, 00, 01, 10 at 2-cycle spacing (AMP=1448, WIDTH=12):
  - `phase` = 2, 2, 3, 2.
  - Levels = (−1448,−1448), (−1448,−1448), (+1448,−1448), (−1448,−1448).
  - Four `sym_valid` pulses, each 1 cycle after its `valid_in`.
- Wrap-around: from reset, dibit 10 four times back-to-back → `phase` = 3, 2, 1, 0. The final levels are (+1448,+1448).
- Idle timeout: dibit 01 (`phase`=1), then no `valid_in`:
  - `active` stays 1 through 15 further edges.
  - On the 16th edge `active`=0, `phase`=0, levels=0, with no `sym_valid`.
  - A following dibit 01 gives `phase`=1.
- Collision: dibit 11 (`phase`=2), then dibit 01 exactly on the 16th idle edge → `phase`=3, `active` remains 1, one `sym_valid`.
- Reset mid-burst: after dibits 11, 01 (`phase`=3), pulse `rstn` low for 3 ns between edges → all outputs 0 immediately. The next dibit 01 gives `phase`=1.
- Held outputs: a 6-cycle gap between dibits (below IDLE_TIMEOUT) → levels and `phase` stay constant through the gap, and `sym_valid` stays 0 in it.

Source files
------------

// File: rtl/dqpsk_diff_mapper.sv
// Differential DQPSK encoder: Gray-coded dibits become phase increments that are
// accumulated modulo 4 and mapped to signed I/Q levels; an idle timeout restores phase 0.
module dqpsk_diff_mapper #(
  parameter int WIDTH        = 12,
  parameter int AMP          = 1448,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  input  logic                    i_data_parallel,
  input  logic                    q_data_parallel,
  output logic                    sym_valid,
  output logic signed [WIDTH-1:0] i_level,
  output logic signed [WIDTH-1:0] q_level,
  output logic [1:0]              phase,
  output logic                    active
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic signed [WIDTH-1:0] LVL_POS  = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] LVL_NEG  = -LVL_POS;
  localparam logic [CW-1:0]           CNT_LAST = CW'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t                    state, state_next;
  logic [CW-1:0]             cnt, cnt_next;
  logic [1:0]                inc;
  logic [1:0]                phase_next;
  logic signed [WIDTH-1:0]   i_next, q_next;
  logic                      sym_next;

  always_comb begin
    unique case ({i_data_parallel, q_data_parallel})
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      default: inc = 2'd3;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    phase_next = phase;
    i_next     = i_level;
    q_next     = q_level;
    sym_next   = 1'b0;

    // A dibit always wins, including on the edge the timeout would fire.
    if (valid_in) begin
      phase_next = phase + inc;
      sym_next   = 1'b1;
      state_next = ACTIVE;
      cnt_next   = '0;
      unique case (phase_next)
        2'd0: begin i_next = LVL_POS; q_next = LVL_POS; end
        2'd1: begin i_next = LVL_NEG; q_next = LVL_POS; end
        2'd2: begin i_next = LVL_NEG; q_next = LVL_NEG; end
        default: begin i_next = LVL_POS; q_next = LVL_NEG; end
      endcase
    end else if (state == ACTIVE) begin
      if (cnt == CNT_LAST) begin
        state_next = IDLE;
        cnt_next   = '0;
        phase_next = '0;
        i_next     = '0;
        q_next     = '0;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= '0;
      i_level   <= '0;
      q_level   <= '0;
      sym_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      phase     <= phase_next;
      i_level   <= i_next;
      q_level   <= q_next;
      sym_valid <= sym_next;
    end
  end

  assign active = (state == ACTIVE);

endmodule

// File: tb/tb_dqpsk_diff_mapper.sv
// Scoreboard bench: stimulus pushes expected symbol/idle events from a phase-angle model,
// a negedge monitor pops them on each DUT event and checks that outputs hold in between.
module tb_dqpsk_diff_mapper;

  localparam int WIDTH = 12;
  localparam int AMP   = 1448;
  localparam int TO    = 16;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b1;
  logic                    valid_in = 1'b0;
  logic                    i_d = 1'b0;
  logic                    q_d = 1'b0;
  logic                    sym_valid;
  logic signed [WIDTH-1:0] i_level, q_level;
  logic [1:0]              phase;
  logic                    active;

  always #5 clk = ~clk;

  dqpsk_diff_mapper #(
    .WIDTH(WIDTH),
    .AMP(AMP),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .valid_in(valid_in),
    .i_data_parallel(i_d),
    .q_data_parallel(q_d),
    .sym_valid(sym_valid),
    .i_level(i_level),
    .q_level(q_level),
    .phase(phase),
    .active(active)
  );

  typedef struct {
    bit is_sym;
    int ph;
    int iv;
    int qv;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_skip = 1'b0;

  int   m_phase = 0;
  bit   m_active = 1'b0;
  int   m_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Level = AMP * sign(cos) and AMP * sign(sin) of the carrier angle (45 + 90*p degrees).
  function automatic int lvl_i(input int p);
    return (p == 1 || p == 2) ? -AMP : AMP;
  endfunction

  function automatic int lvl_q(input int p);
    return (p >= 2) ? -AMP : AMP;
  endfunction

  task automatic step(input bit v, input bit [1:0] d);
    exp_t e;
    @(posedge clk);
    #2;
    valid_in = v;
    i_d      = d[1];
    q_d      = d[0];
    if (v) begin
      // Gray to binary: b1 = g1, b0 = g1 ^ g0
      m_phase  = (m_phase + 2 * int'(d[1]) + int'(d[1] ^ d[0])) % 4;
      m_active = 1'b1;
      m_gap    = 0;
      e = '{is_sym: 1'b1, ph: m_phase, iv: lvl_i(m_phase), qv: lvl_q(m_phase), cyc: cyc + 1};
      sbq.push_back(e);
    end else if (m_active) begin
      m_gap++;
      if (m_gap == TO) begin
        m_active = 1'b0;
        m_phase  = 0;
        m_gap    = 0;
        e = '{is_sym: 1'b0, ph: 0, iv: 0, qv: 0, cyc: cyc + 1};
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sym_valid"}, sym_valid, 0);
    chk({tag, "_i_level"}, i_level, 0);
    chk({tag, "_q_level"}, q_level, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_active"}, active, 0);
  endtask

  // Monitor
  exp_t mexp;
  int   p_phase, p_i, p_q;
  bit   p_active;

  always @(negedge clk) begin
    if (!rstn || mon_skip) begin
      mon_skip = 1'b0;
    end else if (sym_valid || (p_active && !active)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: sym_valid=%0d active=%0d phase=%0d with no expected event (cycle %0d)",
                 sym_valid, active, phase, cyc);
      end else begin
        mexp = sbq.pop_front();
        chk("event_kind", sym_valid, mexp.is_sym);
        chk("event_cycle", cyc, mexp.cyc);
        chk("phase", phase, mexp.ph);
        chk("i_level", i_level, mexp.iv);
        chk("q_level", q_level, mexp.qv);
        chk("active", active, mexp.is_sym);
      end
    end else begin
      chk("hold_phase", phase, p_phase);
      chk("hold_i_level", i_level, p_i);
      chk("hold_q_level", q_level, p_q);
      chk("hold_active", active, p_active);
    end
    p_phase  = phase;
    p_i      = i_level;
    p_q      = q_level;
    p_active = active;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rstn = 1'b0;
    #2 check_zero_outputs("reset");
    @(posedge clk);
    #2 rstn = 1'b1;

    // Dibits 11, 00, 01, 10 at 2-cycle spacing: phase 2, 2, 3, 2
    step(1'b1, 2'b11); step(1'b0, 2'b00);
    step(1'b1, 2'b00); step(1'b0, 2'b00);
    step(1'b1, 2'b01); step(1'b0, 2'b00);
    step(1'b1, 2'b10); step(1'b0, 2'b00);
    idle(TO + 4);

    // Wrap-around: 10 four times back-to-back
    repeat (4) step(1'b1, 2'b10);
    idle(TO + 4);

    // Idle timeout, then a fresh burst from phase 0
    step(1'b1, 2'b01);
    idle(TO);
    step(1'b1, 2'b01);
    idle(TO + 4);

    // Collision: dibit on the 16th idle edge keeps the accumulated phase
    step(1'b1, 2'b11);
    idle(TO - 1);
    step(1'b1, 2'b01);
    idle(TO + 4);

    // Held outputs over a 6-cycle gap
    step(1'b1, 2'b11);
    idle(6);
    step(1'b1, 2'b10);
    idle(6);

    // Reset mid-burst
    step(1'b1, 2'b11); step(1'b1, 2'b01);
    idle(3);
    @(posedge clk);
    #1 rstn = 1'b0;
    mon_skip = 1'b1;
    #1 check_zero_outputs("midreset");
    chk("queue_empty_at_reset", sbq.size(), 0);
    #2 rstn = 1'b1;
    m_phase  = 0;
    m_active = 1'b0;
    m_gap    = 0;
    step(1'b1, 2'b01);
    idle(3);

    // Randomized traffic including gaps around the timeout
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 11) == 0)
        idle(int'($urandom_range(TO - 3, TO + 3)));
      else
        step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
    end

    idle(TO + 4);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
